// File: rtl/comp_pkg.sv
// Shared types and elaboration helpers for the bit-serial magnitude comparator.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit width_ok(input int width);
    return width >= 2;
  endfunction

  function automatic int cycles_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// One-bit magnitude comparator cell; once g_in or l_in is set the verdict is locked.
module comp_bit_cell (
  input  logic x_b,
  input  logic y_b,
  input  logic g_in,
  input  logic l_in,
  output logic g_out,
  output logic l_out
);

  assign g_out = g_in | (~l_in & x_b & ~y_b);
  assign l_out = l_in | (~g_in & ~x_b & y_b);

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial MSB-first magnitude comparator with start/done handshake and
// optional early exit on the first differing bit pair.
module serial_mag_comp_ctrl
  import comp_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               X,
  input  logic [WIDTH-1:0]               Y,
  output logic                           busy,
  output logic                           done,
  output logic                           G,
  output logic                           L,
  output logic                           EQ,
  output logic [cycles_width(WIDTH)-1:0] cycles
);

  localparam int CW = cycles_width(WIDTH);
  localparam int IW = $clog2(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_mag_comp_ctrl: WIDTH must be at least 2");
  end

  state_t           state;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [IW-1:0]    idx;
  logic             g_acc;
  logic             l_acc;
  logic             g_nxt;
  logic             l_nxt;

  // The MSB of each shift register is the bit pair under examination; the
  // running verdict lives in g_acc/l_acc so G/L stay low until DONE.
  comp_bit_cell u_cell (
    .x_b   (x_sr[WIDTH-1]),
    .y_b   (y_sr[WIDTH-1]),
    .g_in  (g_acc),
    .l_in  (l_acc),
    .g_out (g_nxt),
    .l_out (l_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x_sr   <= '0;
      y_sr   <= '0;
      idx    <= '0;
      g_acc  <= 1'b0;
      l_acc  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      G      <= 1'b0;
      L      <= 1'b0;
      EQ     <= 1'b0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_sr   <= X;
            y_sr   <= Y;
            idx    <= IW'(WIDTH - 1);
            g_acc  <= 1'b0;
            l_acc  <= 1'b0;
            G      <= 1'b0;
            L      <= 1'b0;
            EQ     <= 1'b0;
            cycles <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          cycles <= cycles + CW'(1);
          g_acc  <= g_nxt;
          l_acc  <= l_nxt;
          x_sr   <= {x_sr[WIDTH-2:0], 1'b0};
          y_sr   <= {y_sr[WIDTH-2:0], 1'b0};
          if (((g_nxt | l_nxt) && EARLY_EXIT) || (idx == '0)) begin
            state <= DONE;
            done  <= 1'b1;
            G     <= g_nxt;
            L     <= l_nxt;
            EQ    <= ~(g_nxt | l_nxt);
          end else begin
            idx <= idx - IW'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
